// File: rtl/drv_cp_out.sv
// -----------------------------------------------------------------------------
// drv_cp_out -- control-panel output driver
//
// Sends CPU state to the front panel as 5-byte frames over a byte-wide
// valid/ready link. A frame goes out after reset, whenever the live inputs
// differ from what was last sent, on a periodic refresh, and on request.
//
// Frame layout, byte 0 first:
//   B0 = {4'b1010, rotary}   B1 = dw[15:8]   B2 = dw[7:0]
//   B3 = leds[15:8]          B4 = leds[7:0]
// (the panel numbers bits 0..15 from the MSB, so panel dw[0:7] is dw[15:8] here)
//
// Ports
//   clk_sys      in   system clock, all state on the rising edge
//   rst_n        in   asynchronous reset, active low
//   panel_ready  in   panel link up; frames start only while high
//   dw           in   16-bit data word shown on the panel lamps
//   leds         in   16 status lamps
//   rotary       in   rotary switch position echo
//   force_req    in   1-cycle pulse: send a frame even if nothing changed
//   tx_data      out  byte to panel (holds its last value while tx_valid=0)
//   tx_valid     out  tx_data valid
//   tx_ready     in   panel accepts the byte when tx_valid & tx_ready
//   busy         out  high while a frame or the trailing gap is in progress
//   frame_done   out  1-cycle pulse after the last byte is accepted
//
// Parameters
//   REFRESH_CYCLES  clocks between refresh frames; 0 disables refresh
//   GAP_CYCLES      idle clocks inserted after each frame; 0 = no gap
// -----------------------------------------------------------------------------
module drv_cp_out #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int GAP_CYCLES     = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        panel_ready,
    input  logic [15:0] dw,
    input  logic [15:0] leds,
    input  logic [3:0]  rotary,
    input  logic        force_req,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [2:0] LAST_IDX = 3'd4;
    localparam int REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    logic [1:0]       state_reg;
    logic [2:0]       idx_reg;
    logic [39:0]      shadow_reg;
    logic [35:0]      last_reg;      // {rotary, dw, leds} of the last complete frame
    logic             dirty_reg;
    logic             refresh_due_reg;
    logic             force_pend_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_valid_reg;
    logic             frame_done_reg;

    logic [35:0] live_fields;
    logic        change;
    logic        trigger;
    logic        start;
    logic        accept;
    logic        abort;
    logic        last_accept;
    logic        refresh_tick;
    logic [2:0]  next_idx;
    logic [7:0]  shadow_byte [5];

    // Byte view of the frozen frame, B0 in the top byte.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_bytes
            assign shadow_byte[gi] = shadow_reg[39 - 8*gi -: 8];
        end
    endgenerate

    assign live_fields = {rotary, dw, leds};
    assign change      = (live_fields != last_reg);
    // force_req is included directly so a pulse arriving in IDLE starts at once.
    assign trigger     = dirty_reg | change | refresh_due_reg | force_pend_reg | force_req;
    assign start       = (state_reg == ST_IDLE) & panel_ready & trigger;
    assign accept      = tx_valid_reg & tx_ready;
    // Losing the link mid-frame wins over a simultaneous accept.
    assign abort       = (state_reg == ST_SEND) & ~panel_ready;
    assign last_accept = (state_reg == ST_SEND) & panel_ready & accept & (idx_reg == LAST_IDX);
    assign next_idx    = idx_reg + 3'd1;

    // Refresh counter runs in every state and restarts when a frame completes.
    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            logic [REF_W-1:0] ref_cnt_reg;

            always_ff @(posedge clk_sys or negedge rst_n) begin
                if (!rst_n) begin
                    ref_cnt_reg <= '0;
                end else if (refresh_tick || last_accept) begin
                    ref_cnt_reg <= '0;
                end else begin
                    ref_cnt_reg <= ref_cnt_reg + REF_W'(1);
                end
            end

            assign refresh_tick = (ref_cnt_reg == REF_W'(REFRESH_CYCLES - 1));
        end else begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= '0;
            shadow_reg      <= '0;
            last_reg        <= '0;
            dirty_reg       <= 1'b1;
            refresh_due_reg <= 1'b0;
            force_pend_reg  <= 1'b0;
            gap_cnt_reg     <= '0;
            tx_data_reg     <= '0;
            tx_valid_reg    <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            // A refresh falling due on the start edge is kept for the next frame.
            if (refresh_tick) begin
                refresh_due_reg <= 1'b1;
            end else if (start) begin
                refresh_due_reg <= 1'b0;
            end

            if (start) begin
                force_pend_reg <= 1'b0;
            end else if (force_req) begin
                force_pend_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shadow_reg   <= {4'b1010, live_fields};
                        idx_reg      <= '0;
                        tx_data_reg  <= {4'b1010, rotary};
                        tx_valid_reg <= 1'b1;
                        dirty_reg    <= 1'b0;
                        state_reg    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (abort) begin
                        // last_reg is left alone so the whole frame is resent later.
                        tx_valid_reg <= 1'b0;
                        dirty_reg    <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end else if (last_accept) begin
                        tx_valid_reg   <= 1'b0;
                        frame_done_reg <= 1'b1;
                        last_reg       <= shadow_reg[35:0];
                        gap_cnt_reg    <= '0;
                        state_reg      <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end else if (accept) begin
                        idx_reg     <= next_idx;
                        tx_data_reg <= shadow_byte[next_idx];
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_reg == GAP_W'(GAP_LAST)) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end

                default: begin
                    state_reg    <= ST_IDLE;
                    tx_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data    = tx_data_reg;
    assign tx_valid   = tx_valid_reg;
    assign frame_done = frame_done_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_drv_cp_out.sv
// -----------------------------------------------------------------------------
// tb_drv_cp_out -- self-checking bench for drv_cp_out
//
// A transaction-level reference (frame = snapshot of the inputs, list of
// pending reasons, countdowns for gap and refresh) is stepped once per clock
// alongside the DUT; all outputs are compared every cycle, and directed
// scenarios add explicit checks on complete frames collected from the link.
// -----------------------------------------------------------------------------
module tb_drv_cp_out;

    localparam int REFRESH = 100;
    localparam int GAP     = 4;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        panel_ready = 1'b0;
    logic [15:0] dw = '0;
    logic [15:0] leds = '0;
    logic [3:0]  rotary = '0;
    logic        force_req = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        frame_done;

    drv_cp_out #(
        .REFRESH_CYCLES(REFRESH),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .panel_ready(panel_ready),
        .dw         (dw),
        .leds       (leds),
        .rotary     (rotary),
        .force_req  (force_req),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid, m_done, m_sending, m_dirty, m_ref_due, m_fpend;
    logic [7:0]  m_data;
    logic [39:0] m_frame;        // frame being sent
    logic [35:0] m_last;         // content of the last completed frame
    int          m_idx, m_gap_left, m_ref_cnt;

    // Frames observed on the link
    logic [7:0]  cap[$];
    logic [39:0] frames[$];

    task automatic model_reset();
        m_valid = 0; m_done = 0; m_sending = 0; m_dirty = 1; m_ref_due = 0; m_fpend = 0;
        m_data = '0; m_frame = '0; m_last = '0;
        m_idx = 0; m_gap_left = 0; m_ref_cnt = 0;
    endtask

    // Advance by one clock using the inputs currently applied.
    task automatic model_step();
        logic [39:0] snap;
        bit started;
        bit completed;
        bit wrap;
        started   = 0;
        completed = 0;
        m_done    = 0;
        snap      = {4'hA, rotary, dw, leds};
        if (m_sending) begin
            if (!panel_ready) begin
                m_sending = 0; m_valid = 0; m_dirty = 1;
            end else if (tx_ready) begin
                if (m_idx == 4) begin
                    m_sending = 0; m_valid = 0; m_done = 1; completed = 1;
                    m_last = m_frame[35:0];
                    m_gap_left = GAP;
                end else begin
                    m_idx++;
                    m_data = m_frame[39 - 8*m_idx -: 8];
                end
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (panel_ready &&
                     (m_dirty || m_ref_due || m_fpend || force_req || (snap[35:0] != m_last))) begin
            m_frame = snap; m_idx = 0; m_data = snap[39:32];
            m_valid = 1; m_sending = 1; started = 1;
            m_dirty = 0; m_ref_due = 0;
        end
        m_fpend = started ? 1'b0 : (m_fpend | force_req);
        if (REFRESH > 0) begin
            wrap = (m_ref_cnt == REFRESH - 1);
            m_ref_cnt = (wrap || completed) ? 0 : m_ref_cnt + 1;
            if (wrap) m_ref_due = 1;
        end
    endtask

    // One clock: note the byte the DUT is about to hand over, step the model,
    // then compare at the falling edge.
    task automatic step();
        logic [39:0] f;
        if (rst_n && tx_valid && !panel_ready) cap.delete();
        else if (rst_n && tx_valid && tx_ready) cap.push_back(tx_data);
        if (!rst_n) begin
            model_reset();
            cap.delete();
        end else begin
            model_step();
        end
        @(negedge clk_sys);
        check("tx_valid", 40'(tx_valid), 40'(m_valid));
        check("tx_data", 40'(tx_data), 40'(m_data));
        check("frame_done", 40'(frame_done), 40'(m_done));
        check("busy", 40'(busy), 40'(m_sending || (m_gap_left > 0)));
        if (frame_done) begin
            f = '0;
            foreach (cap[i]) f = {f[31:0], cap[i]};
            frames.push_back(f);
            $display("frame %0d: %h (%0d bytes) t=%0t", frames.size(), f, cap.size(), $time);
            cap.delete();
        end
    endtask

    task automatic pulse_force();
        force_req = 1'b1;
        step();
        force_req = 1'b0;
    endtask

    int       n0;
    int       k;
    bit [3:0] pat;

    initial begin
        model_reset();
        dw = 16'h1234; leds = 16'h00FF; rotary = 4'h3;
        panel_ready = 1'b1; tx_ready = 1'b1;
        repeat (3) step();
        check("reset_valid", 40'(tx_valid), 40'(0));
        check("reset_busy", 40'(busy), 40'(0));

        // After reset: one frame A3 12 34 00 FF
        rst_n = 1'b1;
        repeat (12) step();
        check("first_frame_cnt", 40'(frames.size()), 40'(1));
        if (frames.size() > 0) check("first_frame", frames[0], 40'hA3123400FF);

        // No change: refresh frames with identical content
        n0 = frames.size();
        repeat (230) step();
        check("refresh_cnt", 40'(frames.size() - n0), 40'(2));
        for (int i = n0; i < frames.size(); i++) check("refresh_frame", frames[i], 40'hA3123400FF);

        // tx_ready 1-0-0-1; dw changes while B2 is pending
        pat = 4'b1001;
        pulse_force();
        k = 0;
        while (!(m_sending && m_idx == 2) && k < 100) begin
            tx_ready = pat[k % 4];
            step();
            k++;
        end
        check("b2_pending_valid", 40'(tx_valid), 40'(1));
        dw = 16'hBEEF;
        n0 = frames.size();
        for (int i = 0; i < 60; i++) begin
            tx_ready = pat[(k + i) % 4];
            step();
        end
        check("beef_frames", 40'(frames.size() >= n0 + 2), 40'(1));
        if (frames.size() >= n0 + 2) begin
            check("old_dw_frame", frames[n0], 40'hA3123400FF);
            check("new_dw_frame", frames[n0 + 1], 40'hA3BEEF00FF);
        end

        // panel_ready dropped after B1 accepted
        tx_ready = 1'b1;
        repeat (10) step();
        pulse_force();
        k = 0;
        while (!(m_sending && m_idx == 2) && k < 50) begin
            step();
            k++;
        end
        check("abort_reached", 40'(tx_valid), 40'(1));
        n0 = frames.size();
        panel_ready = 1'b0;
        step();
        check("abort_valid", 40'(tx_valid), 40'(0));
        repeat (5) step();
        check("abort_idle", 40'(busy), 40'(0));
        panel_ready = 1'b1;
        repeat (20) step();
        check("resend_cnt", 40'(frames.size() - n0), 40'(1));
        if (frames.size() > n0) check("resend_frame", frames[n0], 40'hA3BEEF00FF);

        // force with no change; a second force while sending gives one more frame
        repeat (20) step();
        n0 = frames.size();
        pulse_force();
        repeat (2) step();
        pulse_force();
        repeat (40) step();
        check("force_frames", 40'(frames.size() - n0), 40'(2));

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            panel_ready = ($urandom_range(0, 19) != 0);
            tx_ready    = ($urandom_range(0, 2) != 0);
            force_req   = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 39))
                0: dw     = 16'($urandom);
                1: leds   = 16'($urandom);
                2: rotary = 4'($urandom);
                3: dw     = dw ^ 16'h0001;
                default: ;
            endcase
            step();
        end
        force_req = 1'b0;

        // asynchronous reset in the middle of a frame
        panel_ready = 1'b1;
        tx_ready = 1'b0;
        repeat (12) step();
        pulse_force();
        repeat (2) step();
        check("prereset_valid", 40'(tx_valid), 40'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 40'(tx_valid), 40'(0));
        check("async_busy", 40'(busy), 40'(0));
        repeat (2) step();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        n0 = frames.size();
        repeat (15) step();
        check("post_reset_frame", 40'(frames.size() - n0), 40'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
